// File: rtl/y86_mem_arbiter.sv
// Shares one fixed-latency 64-bit data memory between the Y86 fetch and
// memory-stage requesters, with starvation guard and address range check.
module y86_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_f_req,
    input  logic [63:0]       i_f_addr,
    output logic              o_f_gnt,
    output logic              o_f_valid,
    output logic [63:0]       o_f_rdata,
    output logic              o_f_err,
    input  logic              i_m_req,
    input  logic              i_m_we,
    input  logic [63:0]       i_m_addr,
    input  logic [63:0]       i_m_wdata,
    output logic              o_m_gnt,
    output logic              o_m_valid,
    output logic [63:0]       o_m_rdata,
    output logic              o_m_err,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [63:0]       o_mem_wdata,
    input  logic [63:0]       i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] r_starve;
    logic [3:0] w_starve_nxt;
    logic       r_side_m;
    logic       r_we;

    logic              w_accept;
    logic              w_win_f;
    logic [63:0]       w_sel_addr;
    logic [63:0]       w_sel_wdata;
    logic              w_sel_we;
    logic              w_sel_err;
    logic              w_resp;
    logic              w_resp_m;
    logic              w_resp_err;
    logic [63:0]       w_resp_data;

    logic              w_f_gnt_nxt;
    logic              w_m_gnt_nxt;
    logic              w_f_valid_nxt;
    logic              w_m_valid_nxt;
    logic [63:0]       w_f_rdata_nxt;
    logic [63:0]       w_m_rdata_nxt;
    logic              w_f_err_nxt;
    logic              w_m_err_nxt;
    logic              w_mem_en_nxt;
    logic              w_mem_we_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [63:0]       w_mem_wdata_nxt;

    // F only beats M once M has won STARVE_MAX contested rounds
    assign w_accept    = (r_state == S_IDLE) && (i_f_req || i_m_req);
    assign w_win_f     = i_f_req &&
                         (!i_m_req || r_starve == 4'(STARVE_MAX));
    assign w_sel_addr  = w_win_f ? i_f_addr : i_m_addr;
    assign w_sel_wdata = w_win_f ? 64'h0 : i_m_wdata;
    assign w_sel_we    = !w_win_f && i_m_we;
    assign w_sel_err   = |w_sel_addr[63:ADDR_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_starve <= '0;
            r_side_m <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_starve <= w_starve_nxt;
            if (w_accept) begin
                r_side_m <= !w_win_f;
                r_we     <= w_sel_we;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_starve_nxt = r_starve;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_sel_err ? S_RESP : S_ISSUE;
                    if (w_win_f) begin
                        w_starve_nxt = '0;
                    end else if (i_f_req && r_starve != 4'(STARVE_MAX)) begin
                        w_starve_nxt = r_starve + 4'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = 4'(LAT - 1);
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read data is sampled on the WAIT->RESP edge; writes/errors return 0
    always_comb begin
        w_resp      = (w_state_nxt == S_RESP);
        w_resp_m    = (r_state == S_IDLE) ? !w_win_f : r_side_m;
        w_resp_err  = (r_state == S_IDLE) && w_sel_err;
        w_resp_data = (r_state == S_WAIT) ? i_mem_rdata : 64'h0;

        w_f_gnt_nxt   = w_accept && w_win_f;
        w_m_gnt_nxt   = w_accept && !w_win_f;
        w_f_valid_nxt = w_resp && !w_resp_m;
        w_m_valid_nxt = w_resp && w_resp_m;
        w_f_rdata_nxt = w_f_valid_nxt ? w_resp_data : o_f_rdata;
        w_m_rdata_nxt = w_m_valid_nxt ? w_resp_data : o_m_rdata;
        w_f_err_nxt   = w_f_valid_nxt ? w_resp_err : o_f_err;
        w_m_err_nxt   = w_m_valid_nxt ? w_resp_err : o_m_err;

        w_mem_en_nxt    = (w_state_nxt == S_ISSUE);
        w_mem_we_nxt    = w_mem_en_nxt && w_sel_we;
        w_mem_addr_nxt  = o_mem_addr;
        w_mem_wdata_nxt = o_mem_wdata;
        if (w_accept && !w_sel_err) begin
            w_mem_addr_nxt  = w_sel_addr[ADDR_W-1:0];
            w_mem_wdata_nxt = w_sel_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_f_gnt     <= 1'b0;
            o_m_gnt     <= 1'b0;
            o_f_valid   <= 1'b0;
            o_m_valid   <= 1'b0;
            o_f_rdata   <= '0;
            o_m_rdata   <= '0;
            o_f_err     <= 1'b0;
            o_m_err     <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_f_gnt     <= w_f_gnt_nxt;
            o_m_gnt     <= w_m_gnt_nxt;
            o_f_valid   <= w_f_valid_nxt;
            o_m_valid   <= w_m_valid_nxt;
            o_f_rdata   <= w_f_rdata_nxt;
            o_m_rdata   <= w_m_rdata_nxt;
            o_f_err     <= w_f_err_nxt;
            o_m_err     <= w_m_err_nxt;
            o_mem_en    <= w_mem_en_nxt;
            o_mem_we    <= w_mem_we_nxt;
            o_mem_addr  <= w_mem_addr_nxt;
            o_mem_wdata <= w_mem_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed bench for y86_mem_arbiter: one LAT=1 instance and one LAT=3
// instance, each backed by a small memory model.
module tb_y86_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        f_req, m_req, m_we;
    logic [63:0] f_addr, m_addr, m_wdata;
    logic        f_gnt, f_valid, f_err, m_gnt, m_valid, m_err;
    logic [63:0] f_rdata, m_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    logic        c_f_req, c_m_req, c_m_we;
    logic [63:0] c_f_addr, c_m_addr, c_m_wdata;
    logic        c_f_gnt, c_f_valid, c_f_err, c_m_gnt, c_m_valid, c_m_err;
    logic [63:0] c_f_rdata, c_m_rdata;
    logic        c_mem_en, c_mem_we;
    logic [9:0]  c_mem_addr;
    logic [63:0] c_mem_wdata, c_mem_rdata;

    int checks = 0;
    int errors = 0;

    y86_mem_arbiter #(.ADDR_W(10), .LAT(1), .STARVE_MAX(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_f_req(f_req), .i_f_addr(f_addr),
        .o_f_gnt(f_gnt), .o_f_valid(f_valid),
        .o_f_rdata(f_rdata), .o_f_err(f_err),
        .i_m_req(m_req), .i_m_we(m_we),
        .i_m_addr(m_addr), .i_m_wdata(m_wdata),
        .o_m_gnt(m_gnt), .o_m_valid(m_valid),
        .o_m_rdata(m_rdata), .o_m_err(m_err),
        .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    y86_mem_arbiter #(.ADDR_W(10), .LAT(3), .STARVE_MAX(4)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_f_req(c_f_req), .i_f_addr(c_f_addr),
        .o_f_gnt(c_f_gnt), .o_f_valid(c_f_valid),
        .o_f_rdata(c_f_rdata), .o_f_err(c_f_err),
        .i_m_req(c_m_req), .i_m_we(c_m_we),
        .i_m_addr(c_m_addr), .i_m_wdata(c_m_wdata),
        .o_m_gnt(c_m_gnt), .o_m_valid(c_m_valid),
        .o_m_rdata(c_m_rdata), .o_m_err(c_m_err),
        .o_mem_en(c_mem_en), .o_mem_we(c_mem_we),
        .o_mem_addr(c_mem_addr), .o_mem_wdata(c_mem_wdata),
        .i_mem_rdata(c_mem_rdata)
    );

    // Memory models: read data is present for exactly one cycle
    logic [63:0] mem1 [0:1023];
    logic [63:0] mem3 [0:1023];
    logic [63:0] p3   [0:2];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_en && !mem_we) ? mem1[mem_addr] : 64'h0;
    end

    always @(posedge clk) begin
        if (c_mem_en && c_mem_we) mem3[c_mem_addr] <= c_mem_wdata;
        p3[0] <= (c_mem_en && !c_mem_we) ? mem3[c_mem_addr] : 64'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign c_mem_rdata = p3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One M transaction on the LAT=1 instance; cyc counts gnt cycle as 1
    task automatic m_txn(input logic we, input logic [63:0] addr,
                         input logic [63:0] wd, output int cyc,
                         output logic [63:0] rd, output logic er,
                         output int en);
        bit g;
        int k;
        m_req = 1'b1;
        m_we = we;
        m_addr = addr;
        m_wdata = wd;
        cyc = -1;
        en = 0;
        g = 0;
        k = 0;
        rd = 64'hx;
        er = 1'bx;
        for (int i = 0; i < 40 && cyc < 0; i++) begin
            tick();
            if (mem_en) en++;
            if (g) k++;
            if (m_gnt) begin
                g = 1;
                k = 1;
                m_req = 1'b0;
            end
            if (m_valid) begin
                cyc = k;
                rd = m_rdata;
                er = m_err;
            end
        end
        m_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({f_gnt, f_valid, f_err, m_gnt, m_valid, m_err, mem_en, mem_we}
            !== 8'h0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0",
                     {f_gnt, f_valid, f_err, m_gnt, m_valid, m_err,
                      mem_en, mem_we});
        end
        checks++;
        if (f_rdata !== 64'h0 || m_rdata !== 64'h0 ||
            mem_addr !== 10'h0 || mem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0",
                     f_rdata, m_rdata, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        int cyc, en;
        logic [63:0] rd;
        logic er;
        m_txn(1'b1, 64'd5, 64'hDEAD, cyc, rd, er, en);
        checks++;
        if (cyc !== 2 || en !== 1 || rd !== 64'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp got cyc=%0d en=%0d rd=%h er=%b exp 2 1 0 0",
                     cyc, en, rd, er);
        end
        checks++;
        if (mem1[5] !== 64'hDEAD) begin
            errors++;
            $display("FAIL wr_mem got %h exp dead", mem1[5]);
        end
        m_txn(1'b0, 64'd5, 64'h0, cyc, rd, er, en);
        checks++;
        if (cyc !== 3 || rd !== 64'hDEAD || er !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp got cyc=%0d rd=%h er=%b exp 3 dead 0",
                     cyc, rd, er);
        end
        m_txn(1'b1, 64'd7, 64'h7777, cyc, rd, er, en);
        m_txn(1'b1, 64'd9, 64'h9999, cyc, rd, er, en);
    endtask

    task automatic test_collision();
        int mg = 0, mv = 0, fg = 0, fv = 0, both = 0;
        logic [63:0] mr = 64'h0, fr = 64'h0;
        f_req = 1'b1;
        f_addr = 64'd7;
        m_req = 1'b1;
        m_we = 1'b0;
        m_addr = 64'd9;
        for (int i = 1; i <= 30 && fv == 0; i++) begin
            tick();
            if (f_gnt && m_gnt) both++;
            if (f_valid && m_valid) both++;
            if (m_gnt) begin
                mg = i;
                m_req = 1'b0;
            end
            if (f_gnt) begin
                fg = i;
                f_req = 1'b0;
            end
            if (m_valid) begin
                mv = i;
                mr = m_rdata;
            end
            if (f_valid) begin
                fv = i;
                fr = f_rdata;
            end
        end
        f_req = 1'b0;
        m_req = 1'b0;
        tick();
        checks++;
        if (mg !== 1 || mv !== 3) begin
            errors++;
            $display("FAIL coll_m got gnt=%0d val=%0d exp 1 3", mg, mv);
        end
        checks++;
        if (fg !== 5 || fv !== 7) begin
            errors++;
            $display("FAIL coll_f got gnt=%0d val=%0d exp 5 7", fg, fv);
        end
        checks++;
        if (mr !== 64'h9999 || fr !== 64'h7777 || both !== 0) begin
            errors++;
            $display("FAIL coll_data got m=%h f=%h both=%0d exp 9999 7777 0",
                     mr, fr, both);
        end
    endtask

    task automatic test_starvation();
        int nm = 0;
        bit fg = 0;
        bit fv = 0;
        logic [63:0] fr = 64'h0;
        f_req = 1'b1;
        f_addr = 64'd7;
        m_req = 1'b1;
        m_we = 1'b1;
        m_addr = 64'd9;
        m_wdata = 64'h9999;
        for (int i = 0; i < 100 && !fg; i++) begin
            tick();
            if (m_gnt) nm++;
            if (f_gnt) begin
                fg = 1;
                f_req = 1'b0;
                m_req = 1'b0;
            end
        end
        f_req = 1'b0;
        m_req = 1'b0;
        for (int i = 0; i < 10 && !fv; i++) begin
            tick();
            if (f_valid) begin
                fv = 1;
                fr = f_rdata;
            end
        end
        tick();
        checks++;
        if (fg !== 1'b1 || nm !== 4) begin
            errors++;
            $display("FAIL starve got fgnt=%0d m_wins=%0d exp 1 4", fg, nm);
        end
        checks++;
        if (fv !== 1'b1 || fr !== 64'h7777) begin
            errors++;
            $display("FAIL starve_f got val=%0d rd=%h exp 1 7777", fv, fr);
        end
        checks++;
        if (m_rdata !== 64'h0) begin
            errors++;
            $display("FAIL wr_rdata0 got %h exp 0", m_rdata);
        end
    endtask

    task automatic test_range();
        int cyc, en;
        logic [63:0] rd;
        logic er;
        m_txn(1'b0, 64'd1024, 64'h0, cyc, rd, er, en);
        checks++;
        if (cyc !== 1 || er !== 1'b1 || rd !== 64'h0 || en !== 0) begin
            errors++;
            $display("FAIL range_1024 got cyc=%0d er=%b rd=%h en=%0d exp 1 1 0 0",
                     cyc, er, rd, en);
        end
        m_txn(1'b1, 64'h8000_0000_0000_0005, 64'h5555, cyc, rd, er, en);
        checks++;
        if (cyc !== 1 || er !== 1'b1 || en !== 0 || mem1[5] !== 64'hDEAD) begin
            errors++;
            $display("FAIL range_hi got cyc=%0d er=%b en=%0d mem=%h exp 1 1 0 dead",
                     cyc, er, en, mem1[5]);
        end
        m_txn(1'b1, 64'd1023, 64'hABC, cyc, rd, er, en);
        checks++;
        if (cyc !== 2 || er !== 1'b0 || en !== 1 || mem1[1023] !== 64'hABC) begin
            errors++;
            $display("FAIL range_1023 got cyc=%0d er=%b en=%0d mem=%h exp 2 0 1 abc",
                     cyc, er, en, mem1[1023]);
        end
        checks++;
        if (f_rdata !== 64'h7777 || f_err !== 1'b0) begin
            errors++;
            $display("FAIL f_hold got %h %b exp 7777 0", f_rdata, f_err);
        end
    endtask

    task automatic test_lat3();
        bit g = 0;
        int k = 0;
        int cyc = -1;
        logic [63:0] rd = 64'h0;
        logic er = 1'b1;
        c_m_req = 1'b1;
        c_m_we = 1'b1;
        c_m_addr = 64'd0;
        c_m_wdata = 64'hA5A5_0000_1234_5678;
        for (int i = 0; i < 10 && !g; i++) begin
            tick();
            if (c_m_gnt) g = 1;
        end
        c_m_req = 1'b0;
        repeat (3) tick();
        g = 0;
        c_f_req = 1'b1;
        c_f_addr = 64'd0;
        for (int i = 0; i < 30 && cyc < 0; i++) begin
            tick();
            if (g) k++;
            if (c_f_gnt) begin
                g = 1;
                k = 1;
                c_f_req = 1'b0;
            end
            if (c_f_valid) begin
                cyc = k;
                rd = c_f_rdata;
                er = c_f_err;
            end
        end
        c_f_req = 1'b0;
        tick();
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL lat3_cyc got %0d exp 5", cyc);
        end
        checks++;
        if (rd !== 64'hA5A5_0000_1234_5678 || er !== 1'b0) begin
            errors++;
            $display("FAIL lat3_data got %h er=%b exp a5a5000012345678 0",
                     rd, er);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, en;
        int nv = 0;
        bit g = 0;
        logic [63:0] rd;
        logic er;
        m_txn(1'b0, 64'd5, 64'h0, cyc, rd, er, en);
        checks++;
        if (m_rdata !== 64'hDEAD) begin
            errors++;
            $display("FAIL pre_rst got %h exp dead", m_rdata);
        end
        m_req = 1'b1;
        m_we = 1'b0;
        m_addr = 64'd5;
        for (int i = 0; i < 10 && !g; i++) begin
            tick();
            if (m_gnt) g = 1;
        end
        m_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_rdata !== 64'h0 || f_rdata !== 64'h0 ||
            mem_addr !== 10'h0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait got m=%h f=%h a=%h v=%b exp 0",
                     m_rdata, f_rdata, mem_addr, m_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            if (m_valid || f_valid || mem_en) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL rst_stray got %0d exp 0", nv);
        end
        g = 0;
        c_f_req = 1'b1;
        c_f_addr = 64'd0;
        for (int i = 0; i < 10 && !g; i++) begin
            tick();
            if (c_f_gnt) g = 1;
        end
        c_f_req = 1'b0;
        checks++;
        if (c_mem_en !== 1'b1) begin
            errors++;
            $display("FAIL issue_en got %b exp 1", c_mem_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (c_mem_en !== 1'b0 || c_f_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_issue got en=%b gnt=%b exp 0 0",
                     c_mem_en, c_f_gnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        repeat (8) begin
            tick();
            if (c_f_valid || c_mem_en) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL rst3_stray got %0d exp 0", nv);
        end
    endtask

    initial begin
        f_req = 1'b0;
        f_addr = 64'h0;
        m_req = 1'b0;
        m_we = 1'b0;
        m_addr = 64'h0;
        m_wdata = 64'h0;
        c_f_req = 1'b0;
        c_f_addr = 64'h0;
        c_m_req = 1'b0;
        c_m_we = 1'b0;
        c_m_addr = 64'h0;
        c_m_wdata = 64'h0;
        test_reset();
        test_write_read();
        test_collision();
        test_starvation();
        test_range();
        test_lat3();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
